hazard_scoreboard: RTL
======================

# hazard_scoreboard

- Producer-side companion to the pipeline forwarding unit.
- Tracks in-flight register writes from issue (ID) to retirement (WB), and drives the ID-stage stall when a source register cannot be supplied by bypass.
- Sits beside the ID/EX pipeline register: consumes decode fields from ID and the write-back port from MEM/WB, and produces the pipeline `stall`.

## Interface

Parameters:
- `CNT_W`, default 2: width of each per-register in-flight counter.
- `MAX_INFLIGHT`, default 3: saturation limit per register. Must be ≤ 2^CNT_W − 1.

Ports:
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_valid` in 1: instruction present in ID.
- `id_rs_addr` in 5: rs source register number.
- `id_rs_used` in 1: instruction reads rs.
- `id_rt_addr` in 5: rt source register number.
- `id_rt_used` in 1: instruction reads rt.
- `id_wr_en` in 1: instruction writes a register.
- `id_wr_addr` in 5: destination register number.
- `id_is_load` in 1: instruction is a load (lw).
- `wb_wr_en` in 1: write-back stage writes the register file this cycle.
- `wb_wr_addr` in 5: write-back destination register.
- `stall` out 1: hold PC and IF/ID; insert bubble into ID/EX. Combinational.
- `pending_mask` out 32: bit n = 1 when counter[n] ≠ 0. Registered.
- `sb_err` out 1: sticky underflow flag. Registered.

## Operation

- State:
  - 31 counters, `cnt[1..31]`, each CNT_W bits. Register 0 is never tracked; its bit in `pending_mask` is always 0.
  - EX-load shadow: `exl_v` (1 bit) and `exl_addr` (5 bits).
  - `sb_err`.
- Accept: `acc = id_valid & ~stall`.
- Issue: `inc[n] = acc & id_wr_en & (id_wr_addr == n) & (n != 0)`.
- Retire: `dec[n] = wb_wr_en & (wb_wr_addr == n) & (n != 0)`.
- Counter update at the clock edge:
  - `inc` only: `cnt[n] + 1`.
  - `dec` only with `cnt[n] > 0`: `cnt[n] − 1`.
  - Both `inc` and `dec`: unchanged.
  - `dec` only with `cnt[n] == 0`: counter stays 0 and `sb_err` sets. `sb_err` clears only on `rst`.
- Effective pending for hazard checks: `eff[n] = cnt[n] − dec[n]`. The register file writes in the first half-cycle, so a same-cycle retirement is not a hazard.
- Source hazard, evaluated separately for rs and rt: `used & (addr != 0) & hazard_cond(addr)`. `hazard_cond` is selected by the configuration below.
- WAW limit: stall when `id_valid & id_wr_en & (id_wr_addr != 0) & eff[id_wr_addr] == MAX_INFLIGHT`.
- `stall = id_valid & (rs_hazard | rt_hazard | waw_limit)`.
- EX-load shadow update each edge:
  - `exl_v <= acc & id_is_load & id_wr_en & (id_wr_addr != 0)`.
  - `exl_addr <= id_wr_addr`.
  - A stall therefore leaves a bubble in the shadow.
- `pending_mask` is the registered OR-reduction of each next-state counter. It reflects state after the edge.

## Timing

- Reset (async, immediate): all counters 0, `exl_v` 0, `exl_addr` 0, `pending_mask` 0, `sb_err` 0. `stall` is 0 while `rst` is high.
- `rst` asserted mid-operation discards all in-flight tracking. The pipeline is flushed by the same reset.
- `stall` has zero-cycle latency from ID and WB inputs. Counter and shadow effects appear one edge after acceptance.
- Issue-to-visible: a writer accepted at edge k is visible to hazard checks in cycle k+1.
- Reads of register 0 never stall. Writes to register 0 are never counted.

## Configuration

- Macro `SCOREBOARD_FWD_EN`.
- Defined (forwarding pipeline): `hazard_cond(a) = exl_v & (exl_addr == a)`.
  - Only load-use stalls, for exactly one cycle.
  - Counters still run for the WAW limit and `pending_mask`.
- Undefined (no bypass): `hazard_cond(a) = eff[a] != 0`.
  - Readers stall until the producing write retires.

## Test plan

- Reset mid-flight: `cnt[5]=2`, `cnt[9]=1`, assert `rst` → `pending_mask=0`, `stall=0`, and `sb_err=0` before the next clock edge.
- Macro undefined: issue `add r5`, next cycle `sub r6,r5,r1` → `stall=1`, staying high until the cycle `wb_wr_en=1`/`wb_wr_addr=5` is presented, when `stall` falls combinationally in that same cycle.
- Macro defined: `lw r8` then `add r2,r8,r8` → `stall=1` for exactly one cycle. `add r9` then `or r3,r9,r0` → `stall=0` throughout.
- Simultaneous events: with `cnt[3]=1`, accept a writer to r3 while WB retires r3 → `cnt[3]` stays 1 and `pending_mask[3]=1`.
- Saturation: three accepted writers to r7 with no retirement → a fourth writer to r7 gets `stall=1`. Retiring one r7 write releases it in the same cycle.
- Underflow: WB retires r4 with `cnt[4]=0` → `sb_err=1` from the next edge and stays set, `cnt[4]` stays 0. Read of r0 while `wb_wr_addr=0` → `stall=0`.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register in-flight write tracking and ID-stage stall generation.
// Define SCOREBOARD_FWD_EN for a forwarding pipeline (load-use stalls only); undefined means no bypass.
module hazard_scoreboard #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs_addr,
    input  logic        id_rs_used,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_rt_used,
    input  logic        id_wr_en,
    input  logic [4:0]  id_wr_addr,
    input  logic        id_is_load,
    input  logic        wb_wr_en,
    input  logic [4:0]  wb_wr_addr,
    output logic        stall,
    output logic [31:0] pending_mask,
    output logic        sb_err
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_INFLIGHT);
    logic [CNT_W-1:0] cnt [32];
    logic [CNT_W-1:0] cnt_nxt [32];
    logic [CNT_W-1:0] eff [32];
    logic [31:0] inc, dec, unf, pend_nxt;
    logic exl_v;
    logic [4:0] exl_addr;
    logic acc, rs_hz, rt_hz, rs_hazard, rt_hazard, waw_limit;
    // A same-cycle retirement already reached the register file, so it no longer counts as pending.
    always_comb begin
        for (int n = 0; n < 32; n++) begin
            dec[n] = wb_wr_en & (wb_wr_addr == 5'(n)) & (n != 0);
            eff[n] = (dec[n] && cnt[n] != '0) ? cnt[n] - ONE : cnt[n];
        end
    end
`ifdef SCOREBOARD_FWD_EN
    assign rs_hz = exl_v & (exl_addr == id_rs_addr);
    assign rt_hz = exl_v & (exl_addr == id_rt_addr);
`else
    logic unused_shadow;
    assign unused_shadow = exl_v ^ (^exl_addr);
    assign rs_hz = eff[id_rs_addr] != '0;
    assign rt_hz = eff[id_rt_addr] != '0;
`endif
    assign rs_hazard = id_rs_used & (id_rs_addr != 5'd0) & rs_hz;
    assign rt_hazard = id_rt_used & (id_rt_addr != 5'd0) & rt_hz;
    assign waw_limit = id_wr_en & (id_wr_addr != 5'd0) & (eff[id_wr_addr] == MAX);
    assign stall = ~rst & id_valid & (rs_hazard | rt_hazard | waw_limit);
    assign acc = id_valid & ~stall;
    always_comb begin
        for (int n = 0; n < 32; n++) begin
            inc[n] = acc & id_wr_en & (id_wr_addr == 5'(n)) & (n != 0);
            unf[n] = dec[n] & ~inc[n] & (cnt[n] == '0);
            cnt_nxt[n] = (inc[n] & ~dec[n]) ? cnt[n] + ONE :
                         (dec[n] & ~inc[n] & (cnt[n] != '0)) ? cnt[n] - ONE : cnt[n];
            pend_nxt[n] = |cnt_nxt[n];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 32; n++) cnt[n] <= '0;
            exl_v        <= 1'b0;
            exl_addr     <= 5'd0;
            pending_mask <= '0;
            sb_err       <= 1'b0;
        end else begin
            for (int n = 0; n < 32; n++) cnt[n] <= cnt_nxt[n];
            exl_v        <= acc & id_is_load & id_wr_en & (id_wr_addr != 5'd0);
            exl_addr     <= id_wr_addr;
            pending_mask <= pend_nxt;
            sb_err       <= sb_err | (|unf);
        end
    end
endmodule
